// File: rtl/dm_access_if.sv
// dm_access_if: requester, grant and data-memory signals of dm_access_ctrl
interface dm_access_if #(
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [1:0]        size0;
  logic [1:0]        size1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              err0;
  logic              err1;
  logic [31:0]       rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, err0, err1, rdata, busy, mem_addr, mem_wdata, mem_we
  );
  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, err0, err1, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: two-requester arbiter and read-modify-write sequencer for a single-port data memory
module dm_access_ctrl #(
  parameter int ADDR_W    = 32,
  parameter bit PRIO_MODE = 1'b0
) (
  input logic        clk,
  input logic        reset,
  dm_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;
  state_t            state;
  state_t            state_nx;
  logic              last;
  logic              win;
  logic              win_q;
  logic              we_q;
  logic              err_q;
  logic              bad;
  logic              word_st;
  logic [1:0]        size_w;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_w;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        sh;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_sh;
  logic [31:0]       lane_rd;
  logic [31:0]       mask;
  logic [31:0]       merged;
  // pick the winner (tie goes to the requester that was not served last, or to 0 in fixed mode) and vet its alignment
  always_comb begin
    win    = bus.req1 & (~bus.req0 | (~PRIO_MODE & ~last));
    size_w = win ? bus.size1 : bus.size0;
    addr_w = win ? bus.addr1 : bus.addr0;
    bad    = (size_w == 2'd3) | ((size_w == 2'd1) & addr_w[0]) | ((size_w == 2'd2) & |addr_w[1:0]);
  end
  // lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    sh      = {addr_q[1:0], 3'b000};
    rd_sh   = bus.mem_rdata >> sh;
    lane_rd = size_q == 2'd2 ? bus.mem_rdata : rd_sh & (size_q == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff);
    mask    = (size_q == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged  = (old_q & ~mask) | ((wdata_q << sh) & mask);
    word_st = we_q & (size_q == 2'd2);
  end
  // next state: sub-word stores take the extra MERGE cycle, rejected accesses skip straight to DONE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? ((bus.req0 | bus.req1) ? (bad ? DONE : ACCESS) : IDLE) :
               state == ACCESS ? ((we_q & ~word_st) ? MERGE : DONE) :
               state == MERGE  ? DONE : IDLE;
  end
  // state register plus request latch, load capture and old-word capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (bus.req0 | bus.req1)) begin
        last    <= win;
        win_q   <= win;
        we_q    <= win ? bus.we1 : bus.we0;
        size_q  <= size_w;
        addr_q  <= addr_w;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
        err_q   <= bad;
      end
      if (state == ACCESS && !we_q) rdata_q <= lane_rd;
      if (state == ACCESS) old_q <= bus.mem_rdata;
    end
  end
  // outputs decoded from state; the write enable is cut by reset so an interrupted merge never lands
  always_comb begin
    bus.gnt0      = (state == DONE) & ~win_q;
    bus.gnt1      = (state == DONE) & win_q;
    bus.err0      = (state == DONE) & ~win_q & err_q;
    bus.err1      = (state == DONE) & win_q & err_q;
    bus.rdata     = rdata_q;
    bus.busy      = state != IDLE;
    bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    bus.mem_we    = ~reset & (((state == ACCESS) & word_st) | (state == MERGE));
    bus.mem_wdata = state == MERGE ? merged : ((state == ACCESS) & word_st) ? wdata_q : 32'h0;
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed checks of arbitration, RMW stores, lane loads, errors and reset
module tb_dm_access_ctrl;
  logic clk;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  int wcnt0 = 0;
  logic [31:0] mem0 [16] = '{default: 32'h0};
  logic [31:0] mem1 [16] = '{default: 32'h0};
  dm_access_if #(.ADDR_W(32)) b0 ();
  dm_access_if #(.ADDR_W(32)) b1 ();
  dm_access_ctrl #(.ADDR_W(32), .PRIO_MODE(1'b0)) u_rr (.clk(clk), .reset(reset), .bus(b0));
  dm_access_ctrl #(.ADDR_W(32), .PRIO_MODE(1'b1)) u_fp (.clk(clk), .reset(reset), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign b0.mem_rdata = mem0[b0.mem_addr[5:2]];
  assign b1.mem_rdata = mem1[b1.mem_addr[5:2]];
  // word-addressed memory models, one per controller, with a write counter on the round-robin one
  always @(posedge clk) begin
    if (b0.mem_we) begin
      mem0[b0.mem_addr[5:2]] <= b0.mem_wdata;
      wcnt0 <= wcnt0 + 1;
    end
    if (b1.mem_we) mem1[b1.mem_addr[5:2]] <= b1.mem_wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int seq [8];
    int n = 0;
    int both = 0;
    int p1g0 = 0;
    int p1g1 = 0;
    {b0.req0, b0.req1, b0.we0, b0.we1, b0.size0, b0.size1} = '0;
    {b0.addr0, b0.addr1, b0.wdata0, b0.wdata1} = '0;
    {b1.req0, b1.req1, b1.we0, b1.we1, b1.size0, b1.size1} = '0;
    {b1.addr0, b1.addr1, b1.wdata0, b1.wdata1} = '0;
    reset = 1'b1;
    repeat (2) tick();
    check("rst_flags", {b0.gnt0, b0.gnt1, b0.err0, b0.err1, b0.busy, b0.mem_we}, 0);
    check("rst_rdata", b0.rdata, 0);
    check("rst_maddr", b0.mem_addr, 0);
    check("rst_mwdata", b0.mem_wdata, 0);
    check("rst_fp_flags", {b1.gnt0, b1.gnt1, b1.busy, b1.mem_we}, 0);
    reset = 1'b0;
    // word store 0x12345678 @0x10 by requester 0
    b0.req0 = 1; b0.we0 = 1; b0.size0 = 2'd2; b0.addr0 = 32'h10; b0.wdata0 = 32'h1234_5678;
    tick();
    b0.req0 = 0;
    check("t1_we", b0.mem_we, 1);
    check("t1_addr", b0.mem_addr, 32'h10);
    check("t1_wdata", b0.mem_wdata, 32'h1234_5678);
    check("t1_gnt_early", b0.gnt0, 0);
    tick();
    check("t1_gnt", {b0.gnt0, b0.err0, b0.mem_we, b0.gnt1}, 4'b1000);
    tick();
    check("t1_idle", {b0.gnt0, b0.busy}, 0);
    check("t1_mem", mem0[4], 32'h1234_5678);
    check("t1_wcnt", wcnt0, 1);
    // byte load @0x11 by requester 1
    b0.req1 = 1; b0.we1 = 0; b0.size1 = 2'd0; b0.addr1 = 32'h11;
    tick();
    b0.req1 = 0;
    check("t2_busy_acc", b0.busy, 1);
    check("t2_gnt_early", b0.gnt1, 0);
    tick();
    check("t2_gnt", {b0.gnt1, b0.err1, b0.gnt0}, 3'b100);
    check("t2_rdata", b0.rdata, 32'h0000_0056);
    check("t2_busy_done", b0.busy, 1);
    tick();
    check("t2_idle", b0.busy, 0);
    check("t2_hold", b0.rdata, 32'h0000_0056);
    // half store 0xBEEF @0x12 as read-modify-write
    b0.req0 = 1; b0.we0 = 1; b0.size0 = 2'd1; b0.addr0 = 32'h12; b0.wdata0 = 32'h0000_beef;
    tick();
    b0.req0 = 0;
    check("t3_acc_we", b0.mem_we, 0);
    tick();
    check("t3_merge", {b0.mem_we, b0.gnt0}, 2'b10);
    check("t3_mwdata", b0.mem_wdata, 32'hbeef_5678);
    tick();
    check("t3_gnt", {b0.gnt0, b0.err0, b0.mem_we}, 3'b100);
    tick();
    check("t3_mem", mem0[4], 32'hbeef_5678);
    check("t3_wcnt", wcnt0, 2);
    // misaligned word load and illegal size both fail at once
    b0.req1 = 1; b0.we1 = 0; b0.size1 = 2'd2; b0.addr1 = 32'h06;
    tick();
    b0.req1 = 0;
    check("t5_misalign", {b0.gnt1, b0.err1, b0.mem_we}, 3'b110);
    tick();
    check("t5_idle", {b0.gnt1, b0.err1, b0.busy}, 0);
    b0.req0 = 1; b0.we0 = 1; b0.size0 = 2'd3; b0.addr0 = 32'h10; b0.wdata0 = 32'hdead_beef;
    tick();
    b0.req0 = 0;
    check("t5_illegal", {b0.gnt0, b0.err0, b0.mem_we}, 3'b110);
    tick();
    check("t5_wcnt", wcnt0, 2);
    check("t5_mem", mem0[4], 32'hbeef_5678);
    // byte store @0x13 interrupted by reset during MERGE
    b0.req0 = 1; b0.we0 = 1; b0.size0 = 2'd0; b0.addr0 = 32'h13; b0.wdata0 = 32'h0000_00aa;
    tick();
    b0.req0 = 0;
    tick();
    check("t6_mwdata", b0.mem_wdata, 32'haaef_5678);
    reset = 1'b1;
    #1;
    check("t6_we_cut", b0.mem_we, 0);
    tick();
    reset = 1'b0;
    check("t6_rst", {b0.busy, b0.gnt0, b0.err0, b0.mem_we}, 0);
    check("t6_rdata", b0.rdata, 0);
    tick();
    check("t6_nognt", {b0.gnt0, b0.busy}, 0);
    check("t6_mem", mem0[4], 32'hbeef_5678);
    check("t6_wcnt", wcnt0, 2);
    // both requesters held high: alternate in round-robin, only 0 in fixed priority
    b0.we0 = 0; b0.we1 = 0; b0.size0 = 2'd2; b0.size1 = 2'd2; b0.addr0 = 32'h10; b0.addr1 = 32'h14;
    b1.we0 = 0; b1.we1 = 0; b1.size0 = 2'd2; b1.size1 = 2'd2; b1.addr0 = 32'h10; b1.addr1 = 32'h14;
    b0.req0 = 1; b0.req1 = 1; b1.req0 = 1; b1.req1 = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b0.gnt0 | b0.gnt1) begin
        if (n < 8) seq[n] = int'(b0.gnt1);
        n++;
      end
      if (b0.gnt0 & b0.gnt1) both++;
      if (b1.gnt0) p1g0++;
      if (b1.gnt1) p1g1++;
    end
    b0.req0 = 0; b0.req1 = 0; b1.req0 = 0; b1.req1 = 0;
    check("t4_rr_count", n, 7);
    for (int i = 0; i < 4; i++) check($sformatf("t4_rr_seq%0d", i), seq[i], i % 2);
    check("t4_rr_both", both, 0);
    check("t4_fp_gnt0", p1g0, 7);
    check("t4_fp_gnt1", p1g1, 0);
    repeat (2) tick();
    check("t4_end_idle", {b0.busy, b1.busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
